// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory read port of the SISC fetch unit: request/address out,
// one-cycle acknowledge with read data back.
interface sisc_fetch_unit_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32
);
   logic [PC_W-1:0]    imem_addr;
   logic               imem_req;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_ack;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/sisc_fetch_unit.sv
// SISC fetch stage: owns PC and IR, fetches from instruction memory over a
// req/ack handshake with timeout, and resolves conditional branches.
module sisc_fetch_unit #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic               pc_rst,
   input  logic               pc_write,
   input  logic               pc_sel,
   input  logic               br_sel,
   input  logic               ir_load,
   input  logic [3:0]         stat,
   sisc_fetch_unit_if.master  imem,
   output logic [INSTR_W-1:0] ir,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [15:0]        imm,
   output logic [PC_W-1:0]    pc,
   output logic               fetch_busy,
   output logic               ir_valid,
   output logic               br_taken,
   output logic               fetch_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [PC_W-1:0]    addr_reg, addr_next;
   logic [INSTR_W-1:0] ir_reg, ir_next;
   logic               ir_valid_reg, ir_valid_next;
   logic               err_reg, err_next;
   logic [PC_W-1:0]    pc_reg, pc_next;
   logic               br_taken_reg, br_taken_next;

   logic [3:0]         opcode_w, mm_w;
   logic [15:0]        imm_w;
   logic [3:0]         flag_hit;
   logic               any_hit;
   logic               br_cond;
   logic [PC_W-1:0]    imm_sext;
   logic [PC_W-1:0]    imm_abs;

   assign opcode_w = ir_reg[31:28];
   assign mm_w     = ir_reg[27:24];
   assign imm_w    = ir_reg[15:0];

   // Branch mask: one hit bit per status flag selected by mm.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_flag_hit
         assign flag_hit[gi] = mm_w[gi] & stat[gi];
      end
   endgenerate

   assign any_hit  = |flag_hit;
   assign imm_sext = PC_W'($signed(imm_w));
   assign imm_abs  = PC_W'(imm_w);

   always_comb begin
      br_cond = 1'b0;
      case (opcode_w)
         4'd4, 4'd5: br_cond = any_hit;
         4'd6, 4'd7: br_cond = ~any_hit;
         default:    br_cond = 1'b0;
      endcase
   end

   // PC update path; independent of the fetch FSM so pc_rst and pc_write
   // take effect in every state.
   always_comb begin
      pc_next       = pc_reg;
      br_taken_next = 1'b0;
      if (pc_rst) begin
         pc_next = '0;
      end else if (pc_write) begin
         if (!pc_sel) begin
            pc_next = pc_reg + PC_W'(1);
         end else if (br_cond) begin
            br_taken_next = 1'b1;
            pc_next       = br_sel ? (pc_reg + imm_sext) : imm_abs;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      addr_next     = addr_reg;
      ir_next       = ir_reg;
      ir_valid_next = ir_valid_reg;
      err_next      = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (!ir_load) begin
               ir_valid_next = 1'b0;
            end else if (!ir_valid_reg) begin
               state_next    = ST_REQ;
               addr_next     = pc_reg;
               ir_valid_next = 1'b0;
            end
         end
         ST_REQ: begin
            cnt_next = '0;
            if (imem.imem_ack) begin
               ir_next       = imem.imem_rdata;
               ir_valid_next = 1'b1;
               state_next    = ST_IDLE;
            end else begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem.imem_ack) begin
               ir_next       = imem.imem_rdata;
               ir_valid_next = 1'b1;
               cnt_next      = '0;
               state_next    = ST_IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               err_next   = 1'b1;
               cnt_next   = '0;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         addr_reg     <= '0;
         ir_reg       <= '0;
         ir_valid_reg <= 1'b0;
         err_reg      <= 1'b0;
         pc_reg       <= '0;
         br_taken_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         addr_reg     <= addr_next;
         ir_reg       <= ir_next;
         ir_valid_reg <= ir_valid_next;
         err_reg      <= err_next;
         pc_reg       <= pc_next;
         br_taken_reg <= br_taken_next;
      end
   end

   assign imem.imem_addr = addr_reg;
   assign imem.imem_req  = (state_reg == ST_REQ);
   assign fetch_busy     = (state_reg != ST_IDLE);
   assign ir             = ir_reg;
   assign opcode         = opcode_w;
   assign mm             = mm_w;
   assign imm            = imm_w;
   assign pc             = pc_reg;
   assign ir_valid       = ir_valid_reg;
   assign br_taken       = br_taken_reg;
   assign fetch_err      = err_reg;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: fetch scoreboard, branch vector
// table, and hand sequences for reset, overlap and timeout corners.
module tb_sisc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_f = 1'b0;
   logic        pc_rst = 1'b0;
   logic        pc_write = 1'b0;
   logic        pc_sel = 1'b0;
   logic        br_sel = 1'b0;
   logic        ir_load = 1'b0;
   logic [3:0]  stat = 4'd0;
   logic [31:0] ir;
   logic [3:0]  opcode, mm;
   logic [15:0] imm, pc;
   logic        fetch_busy, ir_valid, br_taken, fetch_err;

   int errors = 0;
   int checks = 0;
   logic [31:0] sb_q[$];
   logic [15:0] model_pc;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  st;
      logic        sel;
      logic        brs;
      logic [15:0] exp_pc;
      logic        exp_taken;
   } vec_t;

   vec_t vecs[10];

   sisc_fetch_unit_if #(.PC_W(16), .INSTR_W(32)) fif ();

   sisc_fetch_unit #(.PC_W(16), .INSTR_W(32), .TIMEOUT(15)) dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .pc_rst     (pc_rst),
      .pc_write   (pc_write),
      .pc_sel     (pc_sel),
      .br_sel     (br_sel),
      .ir_load    (ir_load),
      .stat       (stat),
      .imem       (fif.master),
      .ir         (ir),
      .opcode     (opcode),
      .mm         (mm),
      .imm        (imm),
      .pc         (pc),
      .fetch_busy (fetch_busy),
      .ir_valid   (ir_valid),
      .br_taken   (br_taken),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One fetch; ack arrives 'delay' cycles after the REQ cycle (0 = in REQ).
   task automatic do_fetch(input logic [31:0] data, input int delay,
                           input logic [15:0] exp_addr, input int hold);
      int cyc;
      logic [31:0] exp_ir;
      ir_load = 1'b1;
      tick();
      cyc = 1;
      check("req_pulse", 32'(fif.imem_req), 32'd1);
      check("fetch_addr", 32'(fif.imem_addr), 32'(exp_addr));
      check("busy_req", 32'(fetch_busy), 32'd1);
      for (int i = 0; i < delay; i++) begin
         tick();
         cyc++;
         check("req_low_wait", 32'(fif.imem_req), 32'd0);
      end
      sb_q.push_back(data);
      fif.imem_ack   = 1'b1;
      fif.imem_rdata = data;
      tick();
      cyc++;
      fif.imem_ack   = 1'b0;
      fif.imem_rdata = $urandom;
      while (!ir_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      if (ir_valid && sb_q.size() > 0) begin
         exp_ir = sb_q.pop_front();
         check("fetch_ir", ir, exp_ir);
      end else begin
         check("ir_valid_seen", 32'(ir_valid), 32'd1);
      end
      check("fetch_latency", 32'(cyc), 32'(2 + delay));
      check("busy_done", 32'(fetch_busy), 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("no_refetch_busy", 32'(fetch_busy), 32'd0);
         check("no_refetch_valid", 32'(ir_valid), 32'd1);
      end
      ir_load = 1'b0;
      tick();
      check("ir_valid_clear", 32'(ir_valid), 32'd0);
      $display("fetch addr=0x%04h data=0x%08h delay=%0d ir=0x%08h", exp_addr, data, delay, ir);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h4F000040, 4'b0001, 1'b1, 1'b0, 16'h0040, 1'b1};
      vecs[1] = '{32'h52000010, 4'b0010, 1'b1, 1'b1, 16'h0050, 1'b1};
      vecs[2] = '{32'h61000020, 4'b0001, 1'b1, 1'b1, 16'h0050, 1'b0};
      vecs[3] = '{32'h71000008, 4'b0010, 1'b1, 1'b1, 16'h0058, 1'b1};
      vecs[4] = '{32'h58000004, 4'b0111, 1'b1, 1'b1, 16'h0058, 1'b0};
      vecs[5] = '{32'h30000100, 4'b1111, 1'b1, 1'b0, 16'h0058, 1'b0};
      vecs[6] = '{32'h4F000001, 4'b0001, 1'b1, 1'b0, 16'h0001, 1'b1};
      vecs[7] = '{32'h5F00FFFE, 4'b0001, 1'b1, 1'b1, 16'hFFFF, 1'b1};
      vecs[8] = '{32'h00000000, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[9] = '{32'h6F000010, 4'b0000, 1'b1, 1'b0, 16'h0010, 1'b1};

      fif.imem_ack   = 1'b0;
      fif.imem_rdata = '0;

      // Reset with other inputs active
      rst_f = 1'b0;
      ir_load = 1'b1;
      pc_write = 1'b1;
      tick();
      tick();
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_req", 32'(fif.imem_req), 32'd0);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_err", 32'(fetch_err), 32'd0);
      check("rst_busy", 32'(fetch_busy), 32'd0);
      check("rst_ir", ir, 32'd0);
      check("rst_br_taken", 32'(br_taken), 32'd0);
      ir_load = 1'b0;
      pc_write = 1'b0;
      rst_f = 1'b1;
      tick();
      $display("reset pc=0x%04h ir=0x%08h", pc, ir);

      // Sequential increments to PC = 3
      pc_write = 1'b1;
      pc_sel = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      pc_write = 1'b0;
      check("pc_inc3", 32'(pc), 32'd3);
      model_pc = 16'h0003;

      // Zero-wait fetch, then hold ir_load without refetch
      do_fetch(32'h81230005, 0, model_pc, 3);
      check("opcode", 32'(opcode), 32'd8);
      check("mm", 32'(mm), 32'd1);
      check("imm", 32'(imm), 32'd5);

      // pc_write alongside an in-flight fetch and its ack
      ir_load = 1'b1;
      tick();
      pc_write = 1'b1;
      pc_sel = 1'b0;
      check("ovl_addr_req", 32'(fif.imem_addr), 32'(model_pc));
      tick();
      check("ovl_addr_wait", 32'(fif.imem_addr), 32'(model_pc));
      check("ovl_pc_wait", 32'(pc), 32'(model_pc + 16'd1));
      fif.imem_ack = 1'b1;
      fif.imem_rdata = 32'h1A2B3C4D;
      tick();
      fif.imem_ack = 1'b0;
      pc_write = 1'b0;
      check("ovl_ir", ir, 32'h1A2B3C4D);
      check("ovl_valid", 32'(ir_valid), 32'd1);
      check("ovl_pc", 32'(pc), 32'(model_pc + 16'd2));
      model_pc = model_pc + 16'd2;
      ir_load = 1'b0;
      tick();
      $display("overlap fetch ir=0x%08h pc=0x%04h", ir, pc);

      // Branch vector table
      for (int v = 0; v < 10; v++) begin
         do_fetch(vecs[v].instr, v % 4, model_pc, 0);
         stat = vecs[v].st;
         pc_sel = vecs[v].sel;
         br_sel = vecs[v].brs;
         pc_write = 1'b1;
         tick();
         pc_write = 1'b0;
         pc_sel = 1'b0;
         check("vec_pc", 32'(pc), 32'(vecs[v].exp_pc));
         check("vec_br_taken", 32'(br_taken), 32'(vecs[v].exp_taken));
         tick();
         check("vec_br_pulse_end", 32'(br_taken), 32'd0);
         model_pc = vecs[v].exp_pc;
         $display("vec %0d instr=0x%08h stat=%b pc=0x%04h taken=%0d", v, vecs[v].instr, vecs[v].st, pc, br_taken);
      end

      // Timeout, with a pc_rst mid-WAIT that must not abort the fetch
      ir_load = 1'b1;
      tick();
      check("to_addr", 32'(fif.imem_addr), 32'(model_pc));
      tick();
      for (int i = 0; i < 14; i++) begin
         if (i == 5) pc_rst = 1'b1;
         tick();
         pc_rst = 1'b0;
         if (i == 5) begin
            check("to_pc_rst", 32'(pc), 32'd0);
            check("to_pc_rst_busy", 32'(fetch_busy), 32'd1);
            check("to_pc_rst_ir", ir, 32'h6F000010);
         end
      end
      check("to_busy_before", 32'(fetch_busy), 32'd1);
      check("to_err_before", 32'(fetch_err), 32'd0);
      tick();
      check("to_err", 32'(fetch_err), 32'd1);
      check("to_busy_after", 32'(fetch_busy), 32'd0);
      check("to_ir_kept", ir, 32'h6F000010);
      check("to_valid", 32'(ir_valid), 32'd0);
      $display("timeout err=%0d ir=0x%08h", fetch_err, ir);

      // Refetch starts since ir_valid is low; reset it mid-WAIT
      tick();
      check("re_req", 32'(fif.imem_req), 32'd1);
      tick();
      tick();
      tick();
      check("err_sticky", 32'(fetch_err), 32'd1);
      rst_f = 1'b0;
      tick();
      check("mid_rst_busy", 32'(fetch_busy), 32'd0);
      check("mid_rst_err", 32'(fetch_err), 32'd0);
      check("mid_rst_ir", ir, 32'd0);
      check("mid_rst_req", 32'(fif.imem_req), 32'd0);
      ir_load = 1'b0;
      rst_f = 1'b1;
      fif.imem_ack = 1'b1;
      fif.imem_rdata = 32'hDEADBEEF;
      tick();
      fif.imem_ack = 1'b0;
      check("late_ack_valid", 32'(ir_valid), 32'd0);
      check("late_ack_ir", ir, 32'd0);
      check("late_ack_busy", 32'(fetch_busy), 32'd0);
      $display("late ack ignored ir=0x%08h valid=%0d", ir, ir_valid);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Instruction-fetch and program-counter stage of the SISC CPU, directly downstream of the control FSM.
- Consumes the controller's pc_rst, pc_write, pc_sel, br_sel and ir_load. Owns the PC and IR registers and runs a request/acknowledge handshake to instruction memory.
- Evaluates branch conditions against the status register.
- Drives opcode/mm back to the controller and imm/register fields to the datapath.

Parameters:
- PC_W, 16: program counter and instruction-memory address width.
- INSTR_W, 32: instruction width. Field map: opcode [31:28], mm [27:24], rs1 [23:20], rs2 [19:16], imm [15:0].
- TIMEOUT, 15: maximum cycles in WAIT before the fetch is abandoned with fetch_err.

Ports:
- clk, in, 1: rising-edge clock, the only clock.
- rst_f, in, 1: reset, synchronous, active-low.
- pc_rst, in, 1: from controller; synchronously clears PC to 0.
- pc_write, in, 1: from controller; update PC this cycle.
- pc_sel, in, 1: 0 = sequential (PC+1), 1 = branch candidate.
- br_sel, in, 1: 0 = absolute target, 1 = PC-relative target.
- ir_load, in, 1: from controller; level request to fetch the instruction at the current PC.
- stat, in, 4: status register flags {C,N,Z,V}.
- imem_addr, out, PC_W: instruction-memory address.
- imem_req, out, 1: memory read request.
- imem_rdata, in, INSTR_W: memory read data; valid when imem_ack is high.
- imem_ack, in, 1: one-cycle read acknowledge.
- ir, out, INSTR_W: instruction register.
- opcode, out, 4: ir[31:28], to controller.
- mm, out, 4: ir[27:24], to controller.
- imm, out, 16: ir[15:0].
- pc, out, PC_W: current PC.
- fetch_busy, out, 1: a fetch is in flight.
- ir_valid, out, 1: IR holds a freshly fetched instruction.
- br_taken, out, 1: one-cycle pulse when a branch updates the PC.
- fetch_err, out, 1: sticky memory-timeout flag.

Behaviour:
- Reset: rst_f low at a rising edge forces all of the following, regardless of other inputs:
  - PC = 0, IR = 0.
  - imem_req, fetch_busy, ir_valid, br_taken, fetch_err = 0.
  - FSM = IDLE, timeout counter = 0.
  - Any in-flight fetch is dropped, and a late imem_ack after reset is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when ir_load = 1 and ir_valid = 0. Latch imem_addr = PC and clear ir_valid.
  - REQ: imem_req = 1 for exactly one cycle; then go to WAIT.
  - WAIT: imem_req = 0 and the counter increments each cycle.
    - On imem_ack = 1: IR <= imem_rdata, ir_valid <= 1, go to IDLE.
    - If the counter reaches TIMEOUT without an ack: fetch_err <= 1, IR unchanged, go to IDLE.
  - An ack arriving in the REQ cycle is accepted as in WAIT (zero-wait memory). Minimum latency from ir_load to ir_valid is 2 cycles.
- fetch_busy = 1 in REQ and WAIT.
- ir_valid clears when ir_load drops to 0. A held ir_load does not refetch.
- imem_addr holds the latched value for the whole fetch. PC updates during REQ/WAIT do not change it.
- PC update happens on a rising edge when pc_write = 1. Priority is pc_rst > pc_write.
  - pc_sel = 0: PC <= PC + 1, wrapping modulo 2^PC_W.
  - pc_sel = 1: the branch is taken only if the condition holds:
    - opcode 4 (BRA) or 5 (BRR): (mm & stat) != 0.
    - opcode 6 (BNE) or 7 (BNR): (mm & stat) == 0.
    - Any other opcode: not taken.
  - Taken, br_sel = 0: PC <= imm[PC_W-1:0].
  - Taken, br_sel = 1: PC <= PC + sign_extend(imm), wrapping.
  - Not taken: PC holds; it was already incremented during fetch.
  - br_taken pulses high for 1 cycle on a taken branch.
- Simultaneous pc_write and imem_ack: both complete in the same cycle. The IR update uses the latched address.
- pc_rst is effective in any FSM state. It does not abort a fetch and does not clear IR.
- fetch_err stays set until rst_f.

Test Plan:
- Reset: hold rst_f = 0 for 2 cycles with ir_load = 1 -> pc = 0, imem_req = 0, ir_valid = 0, fetch_err = 0.
- Zero-wait fetch: PC = 0x0003, ir_load = 1, imem_ack in the REQ cycle with rdata 0x81230005 -> imem_addr = 0x0003, ir = 0x81230005, opcode = 8, mm = 1, ir_valid high 2 cycles after ir_load.
- Relative taken branch: ir = 0x52000010 (BRR, mm = 2), stat = 0b0010, PC = 0x0040, pc_write = pc_sel = br_sel = 1 -> pc = 0x0050, br_taken pulses.
- BNE not taken: ir = 0x61000020, stat = 0b0001 -> pc unchanged, br_taken = 0.
- Negative offset with wrap: BRR, imm = 0xFFFE, PC = 0x0001, condition true -> pc = 0xFFFF.
- Timeout: no imem_ack for 15 WAIT cycles -> fetch_err = 1 and IR unchanged. Reset in the middle of a subsequent WAIT -> FSM returns to IDLE, fetch_err = 0, and a late ack is ignored.
